adv_video_timing: RTL and testbench

//  Pixel-clock video timing generator and pixel pump feeding the ADV7511 DDR output stage.

---
 rtl/adv_video_pkg.sv | 48 ++++
 rtl/adv_video_timing_if.sv | 21 ++
 rtl/adv_timing_counter.sv | 51 +++++
 rtl/adv_video_timing.sv | 185 ++++++++++++++++++
 tb/tb_adv_video_timing.sv | 308 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/adv_video_pkg.sv
// Shared 720p50 timing constants, colour constants and FSM state type for the ADV7511 video path.
// The colour-bar table is only consumed when TEST_PATTERN_EN is defined.
package adv_video_pkg;

    localparam int unsigned H_ACTIVE_720P = 1280;
    localparam int unsigned H_FP_720P     = 440;
    localparam int unsigned H_SYNC_720P   = 40;
    localparam int unsigned H_BP_720P     = 220;
    localparam int unsigned H_TOTAL_720P  = H_ACTIVE_720P + H_FP_720P + H_SYNC_720P + H_BP_720P;

    localparam int unsigned V_ACTIVE_720P = 720;
    localparam int unsigned V_FP_720P     = 5;
    localparam int unsigned V_SYNC_720P   = 5;
    localparam int unsigned V_BP_720P     = 20;
    localparam int unsigned V_TOTAL_720P  = V_ACTIVE_720P + V_FP_720P + V_SYNC_720P + V_BP_720P;

    localparam logic [23:0] COL_BLACK   = 24'h000000;
    localparam logic [23:0] COL_WHITE   = 24'hFFFFFF;
    localparam logic [23:0] COL_YELLOW  = 24'hFFFF00;
    localparam logic [23:0] COL_CYAN    = 24'h00FFFF;
    localparam logic [23:0] COL_GREEN   = 24'h00FF00;
    localparam logic [23:0] COL_MAGENTA = 24'hFF00FF;
    localparam logic [23:0] COL_RED     = 24'hFF0000;
    localparam logic [23:0] COL_BLUE    = 24'h0000FF;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StStopping
    } vt_state_e;

    // Bars run left to right: white, yellow, cyan, green, magenta, red, blue, black.
    function automatic logic [23:0] bar_colour(input logic [2:0] idx);
        logic [23:0] col;
        case (idx)
            3'd0: col = COL_WHITE;
            3'd1: col = COL_YELLOW;
            3'd2: col = COL_CYAN;
            3'd3: col = COL_GREEN;
            3'd4: col = COL_MAGENTA;
            3'd5: col = COL_RED;
            3'd6: col = COL_BLUE;
            3'd7: col = COL_BLACK;
        endcase
        return col;
    endfunction

endpackage

// File: rtl/adv_video_timing_if.sv
// FWFT line-FIFO read port between the upstream pixel FIFO and the video timing generator.
// master: the timing generator (pops); slave: the FIFO (presents the head word).
interface adv_video_timing_if;

    logic [23:0] fifo_data;
    logic        fifo_empty;
    logic        fifo_rd;

    modport master (
        input  fifo_data,
        input  fifo_empty,
        output fifo_rd
    );

    modport slave (
        output fifo_data,
        output fifo_empty,
        input  fifo_rd
    );

endinterface

// File: rtl/adv_timing_counter.sv
// Horizontal/vertical raster counters: advance while run_i is high, held at 0 otherwise.
// frame_end_o flags the last pixel of the last line.
module adv_timing_counter
    import adv_video_pkg::*;
#(
    parameter int unsigned HTotal = H_TOTAL_720P,
    parameter int unsigned VTotal = V_TOTAL_720P
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        run_i,
    output logic [10:0] h_o,
    output logic [9:0]  v_o,
    output logic        frame_end_o
);

    localparam logic [10:0] HLast = 11'(HTotal - 1);
    localparam logic [9:0]  VLast = 10'(VTotal - 1);

    logic [10:0] h_q, h_d;
    logic [9:0]  v_q, v_d;

    always_comb begin
        h_d = h_q;
        v_d = v_q;
        if (!run_i) begin
            h_d = '0;
            v_d = '0;
        end else if (h_q == HLast) begin
            h_d = '0;
            v_d = (v_q == VLast) ? '0 : v_q + 10'd1;
        end else begin
            h_d = h_q + 11'd1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            h_q <= '0;
            v_q <= '0;
        end else begin
            h_q <= h_d;
            v_q <= v_d;
        end
    end

    assign h_o         = h_q;
    assign v_o         = v_q;
    assign frame_end_o = (h_q == HLast) && (v_q == VLast);

endmodule

// File: rtl/adv_video_timing.sv
// Video timing generator and pixel pump for the ADV7511 output stage (720p50 by default).
// Optional colour-bar source enabled by defining TEST_PATTERN_EN (adds input pattern_sel).
module adv_video_timing
    import adv_video_pkg::*;
#(
    parameter int unsigned H_ACTIVE = H_ACTIVE_720P,
    parameter int unsigned H_FP     = H_FP_720P,
    parameter int unsigned H_SYNC   = H_SYNC_720P,
    parameter int unsigned H_BP     = H_BP_720P,
    parameter int unsigned V_ACTIVE = V_ACTIVE_720P,
    parameter int unsigned V_FP     = V_FP_720P,
    parameter int unsigned V_SYNC   = V_SYNC_720P,
    parameter int unsigned V_BP     = V_BP_720P
) (
    input  logic                      clk_in,
    input  logic                      reset_n,
    input  logic                      enable,
`ifdef TEST_PATTERN_EN
    input  logic                      pattern_sel,
`endif
    adv_video_timing_if.master        fifo,
    output logic                      hsync,
    output logic                      vsync,
    output logic                      de,
    output logic [23:0]               data,
    output logic                      frame_start,
    output logic                      underflow,
    output logic [10:0]               x_pos,
    output logic [9:0]                y_pos
);

    localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [10:0] H_ACT_END = 11'(H_ACTIVE);
    localparam logic [10:0] HS_BEG    = 11'(H_ACTIVE + H_FP);
    localparam logic [10:0] HS_END    = 11'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [9:0]  V_ACT_END = 10'(V_ACTIVE);
    localparam logic [9:0]  VS_BEG    = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0]  VS_END    = 10'(V_ACTIVE + V_FP + V_SYNC);

    vt_state_e   state_q;
    logic        hsync_q;
    logic        vsync_q;
    logic        de_q;
    logic [23:0] data_q;
    logic        frame_start_q;
    logic        underflow_q;
    logic [10:0] x_q;
    logic [9:0]  y_q;

    logic [10:0] h_cnt;
    logic [9:0]  v_cnt;
    logic        frame_end;
    logic        running;

    logic        de_nxt;
    logic        hs_nxt;
    logic        vs_nxt;
    logic        fs_nxt;
    logic        pat_on;
    logic [23:0] bar_pix;
    logic [23:0] pix_d;
    logic        pop;
    logic        uf_set;

    assign running = (state_q != StIdle);

    adv_timing_counter #(
        .HTotal (H_TOTAL),
        .VTotal (V_TOTAL)
    ) u_counter (
        .clk_i       (clk_in),
        .rst_ni      (reset_n),
        .run_i       (running),
        .h_o         (h_cnt),
        .v_o         (v_cnt),
        .frame_end_o (frame_end)
    );

    assign de_nxt = running && (h_cnt < H_ACT_END) && (v_cnt < V_ACT_END);
    assign hs_nxt = running && (h_cnt >= HS_BEG) && (h_cnt < HS_END);
    assign vs_nxt = running && (v_cnt >= VS_BEG) && (v_cnt < VS_END);
    assign fs_nxt = running && (h_cnt == 11'd0) && (v_cnt == 10'd0);

`ifdef TEST_PATTERN_EN
    localparam int unsigned BAR_W = H_ACTIVE / 8;

    logic       pat_q;
    logic [2:0] bar_idx;

    // The new selection already applies to the first pixel of the frame it is sampled on.
    assign pat_on = fs_nxt ? pattern_sel : pat_q;

    always_comb begin
        bar_idx = 3'd0;
        for (int i = 1; i < 8; i++) begin
            if (h_cnt >= 11'(i * BAR_W)) begin
                bar_idx = 3'(i);
            end
        end
    end

    assign bar_pix = bar_colour(bar_idx);
`else
    assign pat_on  = 1'b0;
    assign bar_pix = COL_BLACK;
`endif

    always_comb begin
        pix_d  = COL_BLACK;
        pop    = 1'b0;
        uf_set = 1'b0;
        if (de_nxt) begin
            if (pat_on) begin
                pix_d = bar_pix;
            end else if (fifo.fifo_empty) begin
                uf_set = 1'b1;
            end else begin
                pix_d = fifo.fifo_data;
                pop   = 1'b1;
            end
        end
    end

    assign fifo.fifo_rd = pop;

    always_ff @(posedge clk_in or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= StIdle;
            hsync_q       <= 1'b0;
            vsync_q       <= 1'b0;
            de_q          <= 1'b0;
            data_q        <= COL_BLACK;
            frame_start_q <= 1'b0;
            underflow_q   <= 1'b0;
            x_q           <= '0;
            y_q           <= '0;
`ifdef TEST_PATTERN_EN
            pat_q         <= 1'b0;
`endif
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (enable) state_q <= StRun;
                end
                StRun: begin
                    if (!enable) state_q <= StStopping;
                end
                StStopping: begin
                    // Finish the frame in progress so no sync pulse or line is cut short.
                    if (enable) begin
                        state_q <= StRun;
                    end else if (frame_end) begin
                        state_q <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase

            hsync_q       <= hs_nxt;
            vsync_q       <= vs_nxt;
            de_q          <= de_nxt;
            data_q        <= pix_d;
            frame_start_q <= fs_nxt;
            // A fresh underflow on the frame-start pixel overrides the per-frame clear.
            underflow_q   <= uf_set | (underflow_q & ~fs_nxt);
            x_q           <= h_cnt;
            y_q           <= v_cnt;
`ifdef TEST_PATTERN_EN
            if (fs_nxt) pat_q <= pattern_sel;
`endif
        end
    end

    assign hsync       = hsync_q;
    assign vsync       = vsync_q;
    assign de          = de_q;
    assign data        = data_q;
    assign frame_start = frame_start_q;
    assign underflow   = underflow_q;
    assign x_pos       = x_q;
    assign y_pos       = y_q;

endmodule

// File: tb/tb_adv_video_timing.sv
// Scoreboard bench for adv_video_timing on a reduced raster (25x10) so whole frames fit quickly.
// Define TEST_PATTERN_EN to also exercise the colour-bar source.
module tb_adv_video_timing;
    import adv_video_pkg::*;

    localparam int HA = 16, HF = 4, HS = 2, HB = 3;
    localparam int VA = 6, VF = 1, VS = 2, VB = 1;
    localparam int HT = HA + HF + HS + HB;
    localparam int VT = VA + VF + VS + VB;
    localparam int FT = HT * VT;
`ifdef TEST_PATTERN_EN
    localparam bit PatEn = 1'b1;
`else
    localparam bit PatEn = 1'b0;
`endif
    localparam logic [23:0] BARS [8] = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                                         24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};

    logic clk;
    logic reset_n;
    logic en;
    logic psel;
    logic hsync, vsync, de, frame_start, underflow;
    logic [23:0] data;
    logic [10:0] x_pos;
    logic [9:0]  y_pos;

    adv_video_timing_if fifo_if ();

    adv_video_timing #(
        .H_ACTIVE (HA), .H_FP (HF), .H_SYNC (HS), .H_BP (HB),
        .V_ACTIVE (VA), .V_FP (VF), .V_SYNC (VS), .V_BP (VB)
    ) dut (
        .clk_in      (clk),
        .reset_n     (reset_n),
        .enable      (en),
`ifdef TEST_PATTERN_EN
        .pattern_sel (psel),
`endif
        .fifo        (fifo_if),
        .hsync       (hsync),
        .vsync       (vsync),
        .de          (de),
        .data        (data),
        .frame_start (frame_start),
        .underflow   (underflow),
        .x_pos       (x_pos),
        .y_pos       (y_pos)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_total = 0;
    int n_bad   = 0;

    // Reference model: position within the frame as a single cycle index.
    int m_st;
    int m_pos;
    bit m_uf;
    bit m_pat;

    logic [49:0] sb_q [$];
    bit empty_all, uf_mode;

    int cyc, de_cnt, rd_cnt, hs_cnt, vs_cnt, fs_cnt;
    int t_fs, fs_gap, hs_off, vs_off, t_rel;
    bit hs_prev, vs_prev, hs_seen, vs_seen;
    logic [23:0] px_a, px_b, px_c;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [49:0] dut_vec();
        return {hsync, vsync, de, frame_start, underflow, data, x_pos, y_pos};
    endfunction

    task automatic model_reset();
        m_st  = 0;
        m_pos = 0;
        m_uf  = 1'b0;
        m_pat = 1'b0;
    endtask

    task automatic clr_stats();
        de_cnt = 0;
        rd_cnt = 0;
        hs_cnt = 0;
        vs_cnt = 0;
        fs_cnt = 0;
    endtask

    // One pixel clock: score the last edge, drive inputs, check fifo_rd, predict the next edge.
    task automatic step();
        logic [49:0] exp_v;
        logic [23:0] px;
        int h, v;
        bit run, de_m, fs_m, pat_m, hs_m, vs_m, uf_m, rd_m;

        check_val("sb_level", 64'(sb_q.size()), 64'd1);
        if (sb_q.size() > 0) begin
            exp_v = sb_q.pop_front();
            check_val("video", 64'(dut_vec()), 64'(exp_v));
        end
        cyc++;
        if (frame_start) begin
            fs_cnt++;
            fs_gap  = cyc - t_fs;
            t_fs    = cyc;
            hs_seen = 1'b0;
            vs_seen = 1'b0;
        end
        if (de) de_cnt++;
        if (hsync) hs_cnt++;
        if (vsync) vs_cnt++;
        if (hsync && !hs_prev && !hs_seen) begin
            hs_off  = cyc - t_fs;
            hs_seen = 1'b1;
        end
        if (vsync && !vs_prev && !vs_seen) begin
            vs_off  = cyc - t_fs;
            vs_seen = 1'b1;
        end
        hs_prev = hsync;
        vs_prev = vsync;
        if (de && y_pos == 10'd1) begin
            if (x_pos == 11'd0)  px_a = data;
            if (x_pos == 11'd2)  px_b = data;
            if (x_pos == 11'd15) px_c = data;
        end

        h = m_pos % HT;
        v = m_pos / HT;
        fifo_if.fifo_data  = 24'($urandom);
        fifo_if.fifo_empty = empty_all || (uf_mode && v == 0 && h >= 5 && h <= 8);

        run   = (m_st != 0);
        de_m  = run && h < HA && v < VA;
        fs_m  = run && m_pos == 0;
        pat_m = PatEn && (fs_m ? psel : m_pat);
        hs_m  = run && h >= HA + HF && h < HA + HF + HS;
        vs_m  = run && v >= VA + VF && v < VA + VF + VS;
        rd_m  = de_m && !fifo_if.fifo_empty && !pat_m;
        uf_m  = (de_m && fifo_if.fifo_empty && !pat_m) || (m_uf && !fs_m);
        if (!de_m)                  px = 24'h0;
        else if (pat_m)             px = BARS[h / (HA / 8)];
        else if (fifo_if.fifo_empty) px = 24'h0;
        else                        px = fifo_if.fifo_data;

        #1;
        check_val("fifo_rd", 64'(fifo_if.fifo_rd), 64'(rd_m));
        if (fifo_if.fifo_rd) rd_cnt++;
        sb_q.push_back({hs_m, vs_m, de_m, fs_m, uf_m, px, 11'(h), 10'(v)});

        if (fs_m) m_pat = psel;
        m_uf = uf_m;
        case (m_st)
            0: if (en) m_st = 1;
            1: if (!en) m_st = 2;
            default: begin
                if (en) m_st = 1;
                else if (m_pos == FT - 1) m_st = 0;
            end
        endcase
        m_pos = run ? (m_pos + 1) % FT : 0;
        @(negedge clk);
    endtask

    task automatic run_to_pos0();
        for (int i = 0; i < FT + 2 && m_pos != 0; i++) step();
    endtask

    task automatic run_to_pos(input int p);
        for (int i = 0; i < FT + 2 && m_pos != p; i++) step();
    endtask

    // Assert reset between edges; outputs must drop without waiting for a clock.
    task automatic do_reset();
        #2;
        reset_n = 1'b0;
        #1;
        check_val("rst_async", 64'(dut_vec()), 64'd0);
        check_val("rst_rd", 64'(fifo_if.fifo_rd), 64'd0);
        sb_q.delete();
        model_reset();
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        sb_q.push_back('0);
        t_rel = cyc;
    endtask

    initial begin
        reset_n            = 1'b0;
        en                 = 1'b0;
        psel               = 1'b0;
        fifo_if.fifo_data  = '0;
        fifo_if.fifo_empty = 1'b0;
        empty_all = 1'b0;
        uf_mode   = 1'b0;
        cyc = 0; t_fs = 0; fs_gap = -1; hs_off = -1; vs_off = -1; t_rel = 0;
        hs_prev = 1'b0; vs_prev = 1'b0; hs_seen = 1'b0; vs_seen = 1'b0;
        px_a = 24'h123456; px_b = 24'h123456; px_c = 24'h123456;
        model_reset();
        clr_stats();

        @(negedge clk);
        check_val("rst_init", 64'(dut_vec()), 64'd0);
        check_val("rst_init_rd", 64'(fifo_if.fifo_rd), 64'd0);
        @(negedge clk);
        reset_n = 1'b1;
        sb_q.push_back('0);

        // Idle with enable low.
        repeat (500) step();
        check_val("idle_rd_cnt", 64'(rd_cnt), 64'd0);
        check_val("idle_fs_cnt", 64'(fs_cnt), 64'd0);

        // One full frame from idle with the FIFO always ready.
        en = 1'b1;
        clr_stats();
        repeat (FT + 1) step();
        check_val("frame_de_cnt", 64'(de_cnt), 64'(HA * VA));
        check_val("frame_pops", 64'(rd_cnt), 64'(HA * VA));
        check_val("frame_fs_cnt", 64'(fs_cnt), 64'd1);
        check_val("hs_offset", 64'(hs_off), 64'(HA + HF));
        check_val("hs_cnt", 64'(hs_cnt), 64'(HS * VT));
        check_val("vs_offset", 64'(vs_off), 64'((VA + VF) * HT));
        check_val("vs_cnt", 64'(vs_cnt), 64'(VS * HT));
        repeat (FT) step();
        check_val("fs_period", 64'(fs_gap), 64'(FT));

        // Four-pixel FIFO underflow on line 0.
        run_to_pos0();
        uf_mode = 1'b1;
        clr_stats();
        repeat (FT) step();
        uf_mode = 1'b0;
        check_val("uf_pops", 64'(rd_cnt), 64'(HA * VA - 4));
        check_val("uf_hold", 64'(underflow), 64'd1);
        step();
        check_val("uf_fs", 64'(frame_start), 64'd1);
        check_val("uf_clr", 64'(underflow), 64'd0);

        // Drop enable mid-frame and restore it before the frame ends.
        run_to_pos0();
        run_to_pos(3 * HT);
        en = 1'b0;
        repeat (HT) step();
        en = 1'b1;
        run_to_pos0();
        step();
        step();
        check_val("reen_fs_period", 64'(fs_gap), 64'(FT));

        // Drop enable mid-frame and leave it low: frame completes, then idle.
        run_to_pos0();
        clr_stats();
        run_to_pos(3 * HT);
        en = 1'b0;
        repeat (FT) step();
        check_val("stop_de_cnt", 64'(de_cnt), 64'(HA * VA));
        check_val("stop_hs_cnt", 64'(hs_cnt), 64'(HS * VT));
        check_val("stop_vs_cnt", 64'(vs_cnt), 64'(VS * HT));
        check_val("stop_fs_cnt", 64'(fs_cnt), 64'd1);
        check_val("stop_idle_out", 64'(dut_vec()), 64'd0);
        check_val("stop_idle_rd", 64'(fifo_if.fifo_rd), 64'd0);

        // Reset mid-line, then restart with enable already high.
        en = 1'b1;
        step();
        run_to_pos(2 * HT + 10);
        do_reset();
        repeat (3) step();
        // Release edge enters RUN; frame_start is registered on the following edge.
        check_val("rst_fs_latency", 64'(t_fs - t_rel), 64'd3);
        repeat (FT) step();

`ifdef TEST_PATTERN_EN
        // Colour bars with the FIFO empty: no pops, no underflow, selection frame-locked.
        psel      = 1'b1;
        empty_all = 1'b1;
        run_to_pos0();
        clr_stats();
        run_to_pos(3 * HT);
        psel = 1'b0;
        run_to_pos0();
        check_val("pat_pops", 64'(rd_cnt), 64'd0);
        check_val("pat_uf", 64'(underflow), 64'd0);
        check_val("pat_x0", 64'(px_a), 64'h00FFFFFF);
        check_val("pat_x2", 64'(px_b), 64'h00FFFF00);
        check_val("pat_xlast", 64'(px_c), 64'h00000000);
        repeat (HT) step();
        check_val("pat_off_uf", 64'(underflow), 64'd1);
        empty_all = 1'b0;
        repeat (HT) step();
`endif

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
